// File: rtl/coeff_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | coeff_fetch                                                                |
// | Wishbone master that reads NB_COEFF words per tile into a coefficient bank |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module coeff_fetch #(
  parameter int NB_COEFF = 6,
  parameter int NB_TILES = 1200,
  parameter int TIMEOUT  = 255
) (
  input  logic                     clk,
  input  logic                     preset_n,
  input  logic [31:0]              base_adr,
  input  logic                     start,
  input  logic [10:0]              tile_nb,
  output logic                     busy,
  output logic                     coeff_ok,
  output logic                     coeff_err,
  output logic [32*NB_COEFF-1:0]   coeff,
  output logic                     p_wb_CYC_O,
  output logic                     p_wb_STB_O,
  output logic                     p_wb_LOCK_O,
  output logic                     p_wb_WE_O,
  output logic [3:0]               p_wb_SEL_O,
  output logic [31:0]              p_wb_ADR_O,
  input  logic [31:0]              p_wb_DAT_I,
  input  logic                     p_wb_ACK_I
);

  localparam int c_IDX_W = $clog2(NB_COEFF);
  localparam int c_WD_W  = $clog2(TIMEOUT + 1);
  localparam logic [c_IDX_W-1:0] c_LAST     = c_IDX_W'(NB_COEFF - 1);
  localparam logic [c_WD_W-1:0]  c_WD_LIMIT = c_WD_W'(TIMEOUT - 1);
  localparam logic [31:0]        c_STRIDE   = 32'(NB_COEFF * 4);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_DONE = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [c_IDX_W-1:0]  r_idx;
  logic [c_WD_W-1:0]   r_wd;
  logic [31:0]         r_adr;
  logic                r_busy;
  logic                r_cyc;
  logic [3:0]          r_sel;
  logic                r_ok;
  logic                r_err;
  logic [31:0]         r_bank [NB_COEFF];
  logic                w_tile_ok;
  logic [31:0]         w_adr0;

  assign w_tile_ok = (32'(tile_nb) < 32'(NB_TILES));
  // Address arithmetic wraps modulo 2^32 by construction.
  assign w_adr0    = base_adr + (32'(tile_nb) * c_STRIDE);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next = w_tile_ok ? S_READ : S_ERR;
        end
      end
      S_READ: begin
        // An ACK in the same cycle as the watchdog limit takes priority.
        if (p_wb_ACK_I) begin
          if (r_idx == c_LAST) begin
            w_next = S_DONE;
          end
        end else if (r_wd == c_WD_LIMIT) begin
          w_next = S_ERR;
        end
      end
      S_DONE:  w_next = S_IDLE;
      S_ERR:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge preset_n) begin
    if (!preset_n) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_wd    <= '0;
      r_adr   <= '0;
      r_busy  <= 1'b0;
      r_cyc   <= 1'b0;
      r_sel   <= 4'h0;
      r_ok    <= 1'b0;
      r_err   <= 1'b0;
      for (int k = 0; k < NB_COEFF; k++) begin
        r_bank[k] <= '0;
      end
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next != S_IDLE);
      r_cyc   <= (w_next == S_READ);
      r_sel   <= (w_next == S_READ) ? 4'hF : 4'h0;
      r_ok    <= (w_next == S_DONE);
      r_err   <= (w_next == S_ERR);
      case (r_state)
        S_IDLE: begin
          if (w_next == S_READ) begin
            r_adr <= w_adr0;
            r_idx <= '0;
            r_wd  <= '0;
          end
        end
        S_READ: begin
          if (p_wb_ACK_I) begin
            r_bank[r_idx] <= p_wb_DAT_I;
            r_idx         <= r_idx + 1'b1;
            r_adr         <= r_adr + 32'd4;
            r_wd          <= '0;
          end else begin
            r_wd <= r_wd + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  for (genvar k = 0; k < NB_COEFF; k++) begin : g_pack
    assign coeff[32*k +: 32] = r_bank[k];
  end

  assign busy        = r_busy;
  assign coeff_ok    = r_ok;
  assign coeff_err   = r_err;
  assign p_wb_CYC_O  = r_cyc;
  assign p_wb_STB_O  = r_cyc;
  assign p_wb_LOCK_O = r_cyc;
  assign p_wb_WE_O   = 1'b0;
  assign p_wb_SEL_O  = r_sel;
  assign p_wb_ADR_O  = r_adr;

endmodule
`default_nettype wire

// File: tb/tb_coeff_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_coeff_fetch                                                             |
// | Scoreboard bench for coeff_fetch with a modelled Wishbone slave            |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_coeff_fetch;
  localparam int NB = 6;
  localparam int NT = 1200;
  localparam int TO = 255;
  localparam int W  = 32 * NB;

  logic          clk = 1'b0;
  logic          preset_n = 1'b0;
  logic [31:0]   base_adr = '0;
  logic          start = 1'b0;
  logic [10:0]   tile_nb = '0;
  logic          busy, coeff_ok, coeff_err;
  logic [W-1:0]  coeff;
  logic          cyc, stb, lock, we;
  logic [3:0]    sel;
  logic [31:0]   adr;
  logic [31:0]   dat = '0;
  logic          ack = 1'b0;

  always #5 clk = ~clk;

  coeff_fetch #(.NB_COEFF(NB), .NB_TILES(NT), .TIMEOUT(TO)) dut (
    .clk(clk), .preset_n(preset_n), .base_adr(base_adr), .start(start),
    .tile_nb(tile_nb), .busy(busy), .coeff_ok(coeff_ok), .coeff_err(coeff_err),
    .coeff(coeff), .p_wb_CYC_O(cyc), .p_wb_STB_O(stb), .p_wb_LOCK_O(lock),
    .p_wb_WE_O(we), .p_wb_SEL_O(sel), .p_wb_ADR_O(adr), .p_wb_DAT_I(dat),
    .p_wb_ACK_I(ack)
  );

  typedef struct {
    bit           is_err;
    logic [31:0]  adr0;
    logic [W-1:0] bank;
  } exp_t;

  exp_t         sb[$];
  exp_t         mon_e;
  logic [31:0]  mbank [NB];
  int           n_chk = 0;
  int           n_fail = 0;

  int           beat = 0, wcnt = 0, wait_req = 0, stall_beat = -1, stall_cycles = 0;
  bit           cyc_seen = 0;
  logic [31:0]  data_base = '0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Slave: decides ACK/data at the falling edge for the next rising edge.
  always @(negedge clk) begin
    if (!preset_n) begin
      beat = 0; wcnt = 0; ack = 1'b0;
    end else begin
      if (ack) begin
        beat++;
        wcnt = 0;
      end
      ack = 1'b0;
      if (cyc) cyc_seen = 1;
      if (cyc && stb) begin
        if (sb.size() > 0) check("adr", W'(adr), W'(sb[0].adr0 + 32'(4 * beat)));
        check("bus_ctl", W'({sel, we, lock}), W'({4'hF, 1'b0, 1'b1}));
        if (beat == stall_beat) stall_cycles++;
        if (beat != stall_beat && wcnt >= wait_req) begin
          ack = 1'b1;
          dat = data_base + 32'(beat);
        end else begin
          wcnt++;
        end
      end else begin
        beat = 0; wcnt = 0;
      end
    end
  end

  // Monitor: every result pulse consumes one scoreboard entry.
  always @(negedge clk) begin
    if (preset_n && (coeff_ok || coeff_err)) begin
      if (sb.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL unexpected_response: ok=%0b err=%0b expected none", coeff_ok, coeff_err);
      end else begin
        mon_e = sb.pop_front();
        check("resp_err", W'(coeff_err), W'(mon_e.is_err));
        check("resp_ok", W'(coeff_ok), W'(!mon_e.is_err));
        check("coeff", coeff, mon_e.bank);
      end
    end
  end

  task automatic fetch(input logic [31:0] base, input logic [10:0] tile, input int wreq,
                       input int stall, input bit repulse, input logic [31:0] dbase);
    exp_t e;
    int lat, exp_lat, nv;
    bit legal;
    legal = (int'(tile) < NT);
    @(posedge clk); #1;
    wait_req = wreq; stall_beat = stall; stall_cycles = 0; cyc_seen = 0; data_base = dbase;
    nv = !legal ? 0 : (stall >= 0 ? stall : NB);
    for (int k = 0; k < nv; k++) mbank[k] = dbase + 32'(k);
    for (int k = 0; k < NB; k++) e.bank[32*k +: 32] = mbank[k];
    e.is_err = !legal || (stall >= 0);
    e.adr0   = base + 32'(tile) * 32'(NB * 4);
    exp_lat  = !legal ? 1 : (stall >= 0 ? stall * (wreq + 1) + TO + 1 : NB * (wreq + 1) + 1);
    sb.push_back(e);
    base_adr = base; tile_nb = tile; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    while (!(coeff_ok || coeff_err) && lat < 3000) begin
      start = repulse && (lat == 2);
      if (start) tile_nb = 11'd5;
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    check("latency", W'(lat), W'(exp_lat));
    check("busy_at_end", W'({busy, cyc}), W'({1'b1, 1'b0}));
    if (!legal) check("no_cyc_illegal", W'(cyc_seen), W'(0));
    if (stall >= 0) check("stall_cycles", W'(stall_cycles), W'(TO));
    @(posedge clk); #1;
    check("busy_after", W'(busy), W'(0));
    stall_beat = -1;
  endtask

  task automatic check_reset_outs(input string name);
    check(name, W'({busy, coeff_ok, coeff_err, cyc, stb, lock, we, sel, adr}), W'(0));
    check({name, "_coeff"}, coeff, W'(0));
  endtask

  initial begin
    exp_t e;
    logic [31:0] rb;
    int tl;
    for (int k = 0; k < NB; k++) mbank[k] = '0;
    repeat (2) @(negedge clk);
    check_reset_outs("reset");
    @(posedge clk); #1;
    preset_n = 1'b1;

    fetch(32'h1000_0000, 11'd2, 0, -1, 0, 32'hC0);
    fetch(32'h2000_0100, 11'd7, 3, -1, 0, $urandom);
    fetch(32'h3000_0000, 11'd1200, 0, -1, 0, $urandom);
    fetch(32'h4000_0000, 11'd9, 0, 2, 0, $urandom);
    fetch(32'h5000_0000, 11'd3, 2, -1, 1, $urandom);

    // Asynchronous reset after the second ACK of a fetch.
    @(posedge clk); #1;
    wait_req = 0; stall_beat = -1; data_base = $urandom;
    e.is_err = 0; e.adr0 = 32'h6000_0000 + 32'd3 * 32'(NB * 4); e.bank = '0;
    sb.push_back(e);
    base_adr = 32'h6000_0000; tile_nb = 11'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    preset_n = 1'b0;
    #1;
    check_reset_outs("async_reset");
    sb.delete();
    for (int k = 0; k < NB; k++) mbank[k] = '0;
    @(posedge clk); #1;
    preset_n = 1'b1;
    fetch(32'h0800_0000, 11'd1199, 1, -1, 0, $urandom);

    for (int i = 0; i < 20; i++) begin
      rb = $urandom;
      rb[1:0] = 2'b00;
      tl = $urandom_range(0, 1299);
      fetch(rb, 11'(tl), $urandom_range(0, 3), -1, 0, $urandom);
    end

    repeat (3) @(posedge clk);
    if (sb.size() != 0) begin
      n_chk++; n_fail++;
      $display("FAIL leftover_expectations: got %0d expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "global timeout");
  end
endmodule
`default_nettype wire
